micro_cfg_ctrl: RTL and testbench

MICRO_CFG_CTRL -- requirements
Module: micro_cfg_ctrl

---
 rtl/micro_cfg_ctrl.sv | 119 +++++++++++
 tb/tb_micro_cfg_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/micro_cfg_ctrl.sv
// Micro configuration controller: synchronizes micro writes into shadow registers and commits them at frame start.
// Optional macro MICRO_AUTOINC_EN makes every accepted data byte post-increment the address register.
module micro_cfg_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] fpga_port_in,
    input  logic       fpga_rsel,
    input  logic       fpga_write,
    input  logic       frame_start,
    output logic [7:0] bg_r,
    output logic [7:0] bg_g,
    output logic [7:0] bg_b,
    output logic       disp_on,
    output logic       led_1,
    output logic       led_2,
    output logic       commit_pending
);

    typedef enum logic [1:0] {IDLE, ARMED, APPLY} state_t;

    state_t     state;
    state_t     state_next;
    logic       wr_s1;
    logic       wr_s2;
    logic       wr_s3;
    logic       accept;
    logic       data_wr;
    logic       commit_req;
    logic [2:0] addr;
    logic [7:0] sh_r;
    logic [7:0] sh_g;
    logic [7:0] sh_b;
    logic [2:0] sh_ctrl;

    // Flops reset high so a strobe already high at reset release never looks like a new edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_s1 <= 1'b1;
            wr_s2 <= 1'b1;
            wr_s3 <= 1'b1;
        end else begin
            wr_s1 <= fpga_write;
            wr_s2 <= wr_s1;
            wr_s3 <= wr_s2;
        end
    end

    assign accept     = wr_s2 & ~wr_s3;
    assign data_wr    = accept & ~fpga_rsel;
    assign commit_req = data_wr && (addr == 3'd4);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr    <= 3'd0;
            sh_r    <= 8'h00;
            sh_g    <= 8'h00;
            sh_b    <= 8'h30;
            sh_ctrl <= 3'b001;
        end else if (accept) begin
            if (fpga_rsel) begin
                addr <= fpga_port_in[2:0];
            end else begin
                case (addr)
                    3'd0:    sh_r    <= fpga_port_in;
                    3'd1:    sh_g    <= fpga_port_in;
                    3'd2:    sh_b    <= fpga_port_in;
                    3'd3:    sh_ctrl <= fpga_port_in[2:0];
                    default: ;
                endcase
`ifdef MICRO_AUTOINC_EN
                addr <= addr + 3'd1;
`else
                addr <= addr;
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A request arriving in IDLE arms even if frame_start is high that cycle; ARMED absorbs repeats
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (commit_req) state_next = ARMED;
            ARMED:   if (frame_start) state_next = APPLY;
            APPLY:   state_next = commit_req ? ARMED : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Shadow writes in the APPLY cycle are non-blocking, so the copy uses the values held at its start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bg_r    <= 8'h00;
            bg_g    <= 8'h00;
            bg_b    <= 8'h30;
            disp_on <= 1'b1;
            led_1   <= 1'b0;
            led_2   <= 1'b0;
        end else if (state == APPLY) begin
            bg_r    <= sh_r;
            bg_g    <= sh_g;
            bg_b    <= sh_b;
            disp_on <= sh_ctrl[0];
            led_1   <= sh_ctrl[1];
            led_2   <= sh_ctrl[2];
        end
    end

    assign commit_pending = (state != IDLE);

endmodule

// File: tb/tb_micro_cfg_ctrl.sv
// Self-checking bench for micro_cfg_ctrl against a transaction-level register model.
// Honours MICRO_AUTOINC_EN the same way as the design build.
module tb_micro_cfg_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] fpga_port_in = 8'h00;
    logic       fpga_rsel = 1'b0;
    logic       fpga_write = 1'b0;
    logic       frame_start = 1'b0;
    logic [7:0] bg_r;
    logic [7:0] bg_g;
    logic [7:0] bg_b;
    logic       disp_on;
    logic       led_1;
    logic       led_2;
    logic       commit_pending;

    int checks = 0;
    int failures = 0;

    // Model: index 0..2 = R/G/B, index 3 = control bits {led_2, led_1, disp_on}
    logic [7:0] m_sh [4];
    logic [7:0] m_act [4];
    int         m_addr;
    bit         m_pending;

    micro_cfg_ctrl dut (
        .clk(clk),
        .rst(rst),
        .fpga_port_in(fpga_port_in),
        .fpga_rsel(fpga_rsel),
        .fpga_write(fpga_write),
        .frame_start(frame_start),
        .bg_r(bg_r),
        .bg_g(bg_g),
        .bg_b(bg_b),
        .disp_on(disp_on),
        .led_1(led_1),
        .led_2(led_2),
        .commit_pending(commit_pending)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset;
        m_sh[0] = 8'h00; m_sh[1] = 8'h00; m_sh[2] = 8'h30; m_sh[3] = 8'h01;
        for (int i = 0; i < 4; i++) m_act[i] = m_sh[i];
        m_addr = 0;
        m_pending = 1'b0;
    endtask

    task automatic model_data(input logic [7:0] d);
        if (m_addr < 3) m_sh[m_addr] = d;
        else if (m_addr == 3) m_sh[3] = d & 8'h07;
        else if (m_addr == 4) m_pending = 1'b1;
`ifdef MICRO_AUTOINC_EN
        m_addr = (m_addr + 1) % 8;
`endif
    endtask

    task automatic check_output(input string tag);
        chk({tag, ".bg_r"}, bg_r, m_act[0]);
        chk({tag, ".bg_g"}, bg_g, m_act[1]);
        chk({tag, ".bg_b"}, bg_b, m_act[2]);
        chk({tag, ".disp_on"}, {7'd0, disp_on}, {7'd0, m_act[3][0]});
        chk({tag, ".led_1"}, {7'd0, led_1}, {7'd0, m_act[3][1]});
        chk({tag, ".led_2"}, {7'd0, led_2}, {7'd0, m_act[3][2]});
        chk({tag, ".pending"}, {7'd0, commit_pending}, {7'd0, m_pending});
    endtask

    task automatic write_byte(input logic rsel, input logic [7:0] d);
        int hold;
        hold = $urandom_range(3, 5);
        fpga_rsel = rsel;
        fpga_port_in = d;
        fpga_write = 1'b1;
        repeat (hold) tick;
        fpga_write = 1'b0;
        fpga_port_in = 8'($urandom);
        fpga_rsel = 1'($urandom);
        repeat (3) tick;
        if (rsel) m_addr = d % 8;
        else model_data(d);
    endtask

    // Pulse frame_start; an armed commit shows APPLY for exactly one cycle, outputs update after it
    task automatic frame(input string tag);
        frame_start = 1'b1;
        tick;
        frame_start = 1'b0;
        chk({tag, ".apply_pend"}, {7'd0, commit_pending}, {7'd0, m_pending});
        chk({tag, ".apply_bg_r"}, bg_r, m_act[0]);
        tick;
        if (m_pending) begin
            for (int i = 0; i < 4; i++) m_act[i] = m_sh[i];
            m_pending = 1'b0;
        end
        chk({tag, ".after_pend"}, {7'd0, commit_pending}, 8'd0);
        tick;
        check_output(tag);
    endtask

    initial begin
        model_reset();
        repeat (3) tick;
        rst = 1'b0;
        tick;
        check_output("reset");

        // Basic commit with cycle-level latency check on the commit byte
        write_byte(1'b1, 8'h00);
        write_byte(1'b0, 8'hFF);
        write_byte(1'b1, 8'hF4);
        fpga_rsel = 1'b0;
        fpga_port_in = 8'h00;
        fpga_write = 1'b1;
        tick;
        tick;
        chk("latency_n1", {7'd0, commit_pending}, 8'd0);
        tick;
        chk("latency_n2", {7'd0, commit_pending}, 8'd1);
        fpga_write = 1'b0;
        repeat (3) tick;
        model_data(8'h00);
        check_output("pre_frame");
        frame("commit1");

        // Shadow control write without commit must stay invisible
        write_byte(1'b1, 8'h03);
        write_byte(1'b0, 8'h06);
        repeat (3) frame("nocommit");

        // Commit request coinciding with frame_start arms but does not apply
        write_byte(1'b1, 8'h04);
        fpga_rsel = 1'b0;
        fpga_port_in = 8'h00;
        fpga_write = 1'b1;
        tick;
        tick;
        frame_start = 1'b1;
        tick;
        frame_start = 1'b0;
        chk("coinc_pend", {7'd0, commit_pending}, 8'd1);
        tick;
        chk("coinc_noapply", {7'd0, disp_on}, {7'd0, m_act[3][0]});
        chk("coinc_pend2", {7'd0, commit_pending}, 8'd1);
        fpga_write = 1'b0;
        repeat (3) tick;
        model_data(8'h00);
        write_byte(1'b1, 8'h04);
        write_byte(1'b0, 8'h5A);
        check_output("double_req");
        frame("coinc_apply");

        // Address behaviour across consecutive data bytes
        write_byte(1'b1, 8'h00);
        write_byte(1'b0, 8'h11);
        write_byte(1'b0, 8'h22);
        write_byte(1'b0, 8'h33);
        write_byte(1'b1, 8'h04);
        write_byte(1'b0, 8'h00);
        frame("seq3");
        write_byte(1'b1, 8'h07);
        write_byte(1'b0, 8'hAA);
        write_byte(1'b0, 8'hBB);
        write_byte(1'b1, 8'h04);
        write_byte(1'b0, 8'h00);
        frame("wrap");

        // Random register traffic
        for (int k = 0; k < 40; k++) begin
            int op;
            op = $urandom_range(0, 4);
            if (op == 0) write_byte(1'b1, {5'($urandom), 3'($urandom_range(0, 7))});
            else if (op == 1) write_byte(1'b1, {5'($urandom), 3'($urandom_range(0, 4))});
            else if (op == 4) frame("rand_frame");
            else write_byte(1'b0, 8'($urandom));
            check_output("rand");
        end

        // Reset while ARMED with the strobe held high
        write_byte(1'b1, 8'h04);
        write_byte(1'b0, 8'h00);
        chk("armed_before_rst", {7'd0, commit_pending}, 8'd1);
        fpga_rsel = 1'b0;
        fpga_port_in = 8'hAA;
        fpga_write = 1'b1;
        tick;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_output("async_rst");
        tick;
        tick;
        rst = 1'b0;
        repeat (4) tick;
        fpga_write = 1'b0;
        repeat (3) tick;
        check_output("post_rst");
        write_byte(1'b1, 8'h04);
        write_byte(1'b0, 8'h00);
        frame("post_rst_commit");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
